// File: rtl/universal_reg_pkg.sv
// rtl/universal_reg_pkg.sv - mode encodings and shared width for universal_reg
package universal_reg_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_INC  = 3'd6,
    MODE_DEC  = 3'd7
  } mode_e;

endpackage

// File: rtl/universal_reg_next.sv
// rtl/universal_reg_next.sv - combinational next-state and carry for universal_reg
module universal_reg_next
  import universal_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             serial_in,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] next_q,
  output logic             next_carry
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] inc_sum;
  logic [WIDTH:0] dec_diff;

  // The extra MSB of each result is the carry out / borrow out.
  assign inc_sum  = {1'b0, q} + ONE;
  assign dec_diff = {1'b0, q} - ONE;

  always_comb begin
    next_q     = q;
    next_carry = 1'b0;
    case (mode_e'(mode))
      MODE_HOLD: begin
        next_q     = q;
        next_carry = 1'b0;
      end
      MODE_LOAD: next_q = d;
      MODE_SHL: begin
        next_q     = {q[WIDTH-2:0], serial_in};
        next_carry = q[WIDTH-1];
      end
      MODE_SHR: begin
        next_q     = {serial_in, q[WIDTH-1:1]};
        next_carry = q[0];
      end
      MODE_ROL: begin
        next_q     = {q[WIDTH-2:0], q[WIDTH-1]};
        next_carry = q[WIDTH-1];
      end
      MODE_ROR: begin
        next_q     = {q[0], q[WIDTH-1:1]};
        next_carry = q[0];
      end
      MODE_INC: begin
        next_q     = inc_sum[WIDTH-1:0];
        next_carry = inc_sum[WIDTH];
      end
      MODE_DEC: begin
        next_q     = dec_diff[WIDTH-1:0];
        next_carry = dec_diff[WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_reg.sv
// rtl/universal_reg.sv - mode-controlled storage register with clear/preset
// Carry and zero flags are built only when UNIVERSAL_REG_FLAGS_EN is defined.
module universal_reg
  import universal_reg_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] next_q;
  logic             next_carry;

  universal_reg_next #(.WIDTH(WIDTH)) u_next (
    .q         (q_r),
    .d         (d),
    .serial_in (serial_in),
    .mode      (mode),
    .next_q    (next_q),
    .next_carry(next_carry)
  );

  always_ff @(posedge clk) begin
    if (!clear)      q_r <= '0;
    else if (preset) q_r <= PRESET_VALUE;
    else             q_r <= next_q;
  end

  assign q     = q_r;
  assign q_bar = ~q_r;

`ifdef UNIVERSAL_REG_FLAGS_EN
  logic carry_r;

  // HOLD is the only mode that keeps the previous carry.
  always_ff @(posedge clk) begin
    if (!clear)                        carry_r <= 1'b0;
    else if (preset)                   carry_r <= 1'b0;
    else if (mode_e'(mode) != MODE_HOLD) carry_r <= next_carry;
  end

  assign carry = carry_r;
  assign zero  = (q_r == '0);
`else
  logic unused_carry;
  assign unused_carry = next_carry;
  assign carry        = 1'b0;
  assign zero         = 1'b0;
`endif

endmodule

// File: tb/tb_universal_reg.sv
// tb/tb_universal_reg.sv - scoreboard testbench for universal_reg (WIDTH=8)
module tb_universal_reg;

  logic       clk = 1'b0;
  logic       clear, preset, serial_in;
  logic [2:0] mode;
  logic [7:0] d, q, q_bar;
  logic       carry, zero;

  typedef struct packed {
    logic [7:0] q;
    logic       c;
    logic       z;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] mq = 8'h00;
  logic       mc = 1'b0;

  universal_reg #(.WIDTH(8)) dut (
    .clk      (clk),
    .clear    (clear),
    .preset   (preset),
    .mode     (mode),
    .d        (d),
    .serial_in(serial_in),
    .q        (q),
    .q_bar    (q_bar),
    .carry    (carry),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour written from the operation table, bit by bit.
  task automatic model(input logic clr, input logic pre, input logic [2:0] md,
                       input logic [7:0] dd, input logic si);
    exp_t e;
    logic [7:0] old;
    old = mq;
    if (!clr) begin
      mq = 8'h00; mc = 1'b0;
    end else if (pre) begin
      mq = 8'hFF; mc = 1'b0;
    end else begin
      case (md)
        3'd0: ;
        3'd1: begin mq = dd; mc = 1'b0; end
        3'd2: begin mc = old[7]; mq = (old << 1) | {7'b0, si}; end
        3'd3: begin mc = old[0]; mq = (old >> 1) | {si, 7'b0}; end
        3'd4: begin mc = old[7]; mq = (old << 1) | (old >> 7); end
        3'd5: begin mc = old[0]; mq = (old >> 1) | (old << 7); end
        3'd6: begin mc = (old == 8'hFF); mq = old + 8'd1; end
        default: begin mc = (old == 8'h00); mq = old - 8'd1; end
      endcase
    end
    e.q = mq;
`ifdef UNIVERSAL_REG_FLAGS_EN
    e.c = mc;
    e.z = (mq == 8'h00);
`else
    e.c = 1'b0;
    e.z = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic step(input logic clr, input logic pre, input logic [2:0] md,
                      input logic [7:0] dd, input logic si);
    exp_t e;
    clear = clr; preset = pre; mode = md; d = dd; serial_in = si;
    model(clr, pre, md, dd, si);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("q",     {24'b0, q},     {24'b0, e.q});
      check("q_bar", {24'b0, q_bar}, {24'b0, ~e.q});
      check("carry", {31'b0, carry}, {31'b0, e.c});
      check("zero",  {31'b0, zero},  {31'b0, e.z});
    end
  endtask

  initial begin
    clear = 1'b0; preset = 1'b0; mode = 3'd0; d = 8'h00; serial_in = 1'b0;
    #1;
    // Reset held with LOAD pending, then released
    step(1'b0, 1'b0, 3'd1, 8'h5A, 1'b0);
    step(1'b0, 1'b0, 3'd1, 8'h5A, 1'b0);
    check("reset_q", {24'b0, q}, 32'h00);
    step(1'b1, 1'b0, 3'd1, 8'h5A, 1'b0);
    check("release_load", {24'b0, q}, 32'h5A);

    // Increment wrap and decrement borrow
    step(1'b1, 1'b0, 3'd1, 8'hFE, 1'b0);
    step(1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
    check("inc_ff", {24'b0, q}, 32'hFF);
    step(1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
    check("inc_wrap", {24'b0, q}, 32'h00);
    step(1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    check("dec_wrap", {24'b0, q}, 32'hFF);
    step(1'b1, 1'b0, 3'd7, 8'h00, 1'b0);

    // Shifts and rotates from 0x81
    step(1'b1, 1'b0, 3'd1, 8'h81, 1'b0);
    step(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    check("shl", {24'b0, q}, 32'h02);
    step(1'b1, 1'b0, 3'd1, 8'h81, 1'b0);
    step(1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
    check("ror", {24'b0, q}, 32'hC0);
    step(1'b1, 1'b0, 3'd1, 8'h81, 1'b0);
    step(1'b1, 1'b0, 3'd3, 8'h00, 1'b1);
    check("shr", {24'b0, q}, 32'hC0);
    step(1'b1, 1'b0, 3'd1, 8'h81, 1'b0);
    step(1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
    step(1'b1, 1'b0, 3'd2, 8'h00, 1'b1);
    step(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);

    // Priority: preset over INC, clear over preset
    step(1'b1, 1'b0, 3'd1, 8'h10, 1'b0);
    step(1'b1, 1'b1, 3'd6, 8'h00, 1'b0);
    check("preset_over_inc", {24'b0, q}, 32'hFF);
    step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
    check("clear_over_preset", {24'b0, q}, 32'h00);

    // Hold with carry set, inputs toggling
    step(1'b1, 1'b0, 3'd1, 8'h80, 1'b0);
    step(1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 3'd0, (i % 2) ? 8'hAA : 8'h55, i[0]);
    check("hold_q", {24'b0, q}, 32'h01);

    // Random sweep across all modes
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 9) == 0),
           3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/universal_reg.md
# universal_reg

Parametrised, mode-controlled storage register for the 8-bit datapath, replacing per-bit flip-flop instances in the A/B/PC/MAR-style registers. Each cycle it holds, loads, shifts, rotates, increments or decrements a WIDTH-bit word, with synchronous clear and preset. It also produces a carry/borrow bit and a zero flag for the control unit.

## Interface
- WIDTH, 8: word width in bits; legal values are 2 to 32.
- PRESET_VALUE, all ones (WIDTH bits): the value loaded when preset is asserted.
- clk  input  1  the single clock; all state updates on its rising edge.
- clear  input  1  synchronous, active-low reset.
- preset  input  1  synchronous, active-high; loads PRESET_VALUE.
- mode  input  3  operation select, encoded per universal_reg_pkg.
- d  input  WIDTH  parallel load data.
- serial_in  input  1  fill bit for the SHL and SHR modes.
- q  output  WIDTH  the register contents.
- q_bar  output  WIDTH  the bitwise inverse of q; always equals ~q.
- carry  output  1  registered carry, borrow or shifted-out bit.
- zero  output  1  high when q == 0.

## Operation
- **Reset (clear = 0 at a clock edge).**
  - q <= 0, carry <= 0.
  - Therefore q_bar = all ones and zero = 1.
  - clear overrides every other input.
- **Preset (clear = 1, preset = 1).**
  - q <= PRESET_VALUE, carry <= 0.
  - preset overrides mode.
- **Mode operations (clear = 1, preset = 0).** mode selects the operation:
  - 0 HOLD: q and carry unchanged.
  - 1 LOAD: q <= d; carry <= 0.
  - 2 SHL: q <= {q[W-2:0], serial_in}; carry <= q[W-1].
  - 3 SHR: q <= {serial_in, q[W-1:1]}; carry <= q[0].
  - 4 ROL: q <= {q[W-2:0], q[W-1]}; carry <= q[W-1].
  - 5 ROR: q <= {q[0], q[W-1:1]}; carry <= q[0].
  - 6 INC: q <= q + 1, modulo 2^WIDTH; carry <= 1 only when q was all ones (wrap to 0).
  - 7 DEC: q <= q - 1, modulo 2^WIDTH; carry <= 1 only when q was 0 (borrow, wrap to all ones).
- **Arithmetic width.** Compute in WIDTH+1 bits. The MSB of the result is the carry/borrow; the result is truncated to WIDTH bits for q.
- **Inputs are sampled at the edge.** d, serial_in, mode and preset are sampled only at the rising edge; changes between edges have no effect.

## Timing
- **Latency.** One cycle: the result of an operation sampled at edge N appears on q and carry immediately after edge N.
- **Combinational outputs.** q_bar and zero are combinational from the q register. They settle in the same cycle as q; no added latency.
- **Back-to-back operations.** Each cycle operates on the q value produced by the previous cycle, e.g. INC,INC,INC from 0 gives 1, 2, 3.
- **Reset mid-operation.**
  - A clear at any edge discards the operation requested on that edge.
  - The first operation is executed at the edge after clear returns high.
- **Simultaneous controls.** Priority is clear > preset > mode. preset = 1 together with INC still loads PRESET_VALUE.
- **Illegal mode values.** None exist: all 8 encodings are defined.

## Configuration
- Macro: UNIVERSAL_REG_FLAGS_EN.
- **With the macro defined:** carry and zero behave exactly as described above.
- **Without the macro:**
  - The carry register is not built.
  - carry and zero are tied to 0.
  - q, q_bar and all mode behaviour are unchanged.
  - The ports remain present so parent modules compile either way.

## Structure
- **universal_reg_pkg** holds:
  - the 3-bit mode type and its eight named constants (MODE_HOLD … MODE_DEC);
  - the default WIDTH constant, shared by the datapath registers.
- **Sub-module universal_reg_next** is combinational:
  - inputs: q, d, serial_in, mode;
  - outputs: next_q and next_carry.
  - The top level contains only the priority mux (clear/preset/next) and the flops.

## Test plan
All cases use WIDTH=8.
- **Reset:** hold clear=0 for 2 cycles with mode=LOAD, d=0x5A -> q=0x00, q_bar=0xFF, carry=0, zero=1. Release clear -> next edge gives q=0x5A.
- **Increment wrap:** LOAD 0xFE, then INC, INC -> q=0xFF with carry=0, then q=0x00 with carry=1 and zero=1. DEC from 0x00 -> q=0xFF, carry=1.
- **Shifts and rotates:** LOAD 0x81.
  - SHL with serial_in=0 -> q=0x02, carry=1.
  - From 0x81, ROR -> q=0xC0, carry=1.
  - From 0x81, SHR with serial_in=1 -> q=0xC0, carry=1.
- **Priority:** q=0x10; assert preset=1 with mode=INC -> q=0xFF (PRESET_VALUE). Assert clear=0 and preset=1 together -> q=0x00.
- **Hold:** mode=HOLD for 5 cycles with d and serial_in toggling -> q and carry unchanged.
- **Macro off:** build without UNIVERSAL_REG_FLAGS_EN and repeat the increment-wrap case -> carry=0 and zero=0 throughout; q sequence identical.
